uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL expose parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 The block SHALL expose parameter OVERSAMPLE, default 16, meaning baud_tick pulses per bit; legal values are 8 and 16.
REQ-003 The block SHALL expose parameter PARITY_EN, default 0, meaning 1 = a parity bit follows the data bits.
REQ-004 The block SHALL expose parameter PARITY_ODD, default 0, meaning 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
REQ-005 The block SHALL expose parameter STOP_BITS, default 1, meaning stop bits checked per frame, 1 or 2.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port baud_tick, input, 1 bit: one-clk pulse at OVERSAMPLE x baud rate, from the external generator.
REQ-009 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-010 The block SHALL have port rx_data, output, DATA_BITS bits: received word, LSB first on the line.
REQ-011 The block SHALL have port rx_valid, output, 1 bit: one-clk pulse marking rx_data and all error flags as valid.
REQ-012 The block SHALL have ports parity_err, frame_err and break_det, each output, 1 bit: error flags, valid with rx_valid.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use; all rx references below mean the synchronized signal.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY is skipped when PARITY_EN = 0.
REQ-015 In IDLE, a baud_tick with rx = 0 SHALL clear the tick counter and bit index, then enter START.
REQ-016 Bit timing: the tick counter counts baud_tick from 0 to OVERSAMPLE-1 and wraps to 0, marking the end of each bit.
REQ-017 Bit sampling: with M = OVERSAMPLE/2, rx is sampled at counts M-1, M and M+1, and the bit value is the 2-of-3 majority vote, decided at M+1.
REQ-018 START SHALL return to IDLE if the start-bit vote is 1 (false-start rejection), and otherwise enter DATA at the counter wrap.
REQ-019 DATA SHALL shift voted bits in LSB first; after bit DATA_BITS-1 wraps, it SHALL enter PARITY or STOP.
REQ-020 PARITY: parity_err SHALL be 1 when the XOR of the data bits and the parity bit is not equal to PARITY_ODD.
REQ-021 STOP: frame_err SHALL be 1 if any stop-bit vote is 0; after the vote of the final stop bit, the FSM SHALL go directly to IDLE without waiting for the counter wrap.
REQ-022 rx_valid SHALL pulse for exactly one clk, on the cycle after the baud_tick that decides the final stop bit; the frame is always delivered, even with error flags set.
REQ-023 break_det SHALL be 1 when all data bits are 0, parity (if enabled) is 0, and frame_err = 1.
REQ-024 rx_data and the error flags SHALL hold their values until the next rx_valid pulse.
REQ-025 The block SHALL accept back-to-back frames: a start edge detected in IDLE immediately after STOP begins a new frame with no lost bits.
REQ-026 Clock cycles without baud_tick SHALL leave the counter, the samples and the state unchanged.

Reset
REQ-027 While rst_n = 0, the FSM SHALL be in IDLE, the counters at 0, and rx_data, rx_valid, parity_err, frame_err and break_det all 0.
REQ-028 While rst_n = 0, the synchronizer flops SHALL reset to 1 (line idle).
REQ-029 Reset asserted mid-frame SHALL discard the partial frame, with no rx_valid pulse after release.

Structure
REQ-030 A shared package uart_pkg SHALL hold the FSM state encodings and the legal OVERSAMPLE and STOP_BITS constants, so they can be reused by the transmitter.
REQ-031 The synchronizer SHALL be a separate sub-module, uart_sync2; all other logic is in uart_rx_cfg.

Verification
REQ-032 8N1, OVERSAMPLE = 16, send 0xA5 -> one rx_valid pulse, rx_data = 0xA5, all error flags 0.
REQ-033 8E1, send 0x3C with parity bit 1 -> rx_valid pulse, rx_data = 0x3C, parity_err = 1; repeat with parity bit 0 -> parity_err = 0.
REQ-034 rx low for 4 ticks then high -> no rx_valid, FSM back in IDLE; a 1-tick glitch at count M of a data bit in 0x0F -> rx_data = 0x0F.
REQ-035 Send 0x00 with the stop bit held 0 -> rx_data = 0x00, frame_err = 1, break_det = 1.
REQ-036 DATA_BITS = 7, STOP_BITS = 2, back-to-back 0x55 then 0x2A -> two rx_valid pulses with the correct data; a second stop bit of 0 -> frame_err = 1.
REQ-037 Assert rst_n low during data bit 3, then release and send 0x81 -> no pulse for the aborted frame, then rx_data = 0x81 with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM encodings, legal frame
// constants and the 2-of-3 majority vote used for bit sampling.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int OVS_8    = 8;
  localparam int OVS_16   = 16;
  localparam int STOP_ONE = 1;
  localparam int STOP_TWO = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset
// to the idle (high) level so no false start is seen coming out of reset.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver: start-bit validation, 2-of-3
// majority sampling, optional parity, 1 or 2 stop bits, break detection.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  // Out-of-range settings fall back to the defaults rather than mis-timing.
  localparam int OVS   = (OVERSAMPLE == OVS_8) ? OVS_8 : OVS_16;
  localparam int NSTOP = (STOP_BITS == STOP_TWO) ? STOP_TWO : STOP_ONE;
  localparam int CW    = $clog2(OVS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(OVS - 1);
  localparam logic [CW-1:0] SMP_FIRST = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] SMP_MID   = CW'(OVS / 2);
  localparam logic [CW-1:0] SMP_LAST  = CW'(OVS / 2 + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(NSTOP - 1);
  localparam bit            HAS_PAR   = (PARITY_EN != 0);
  localparam logic          ODD_PAR   = (PARITY_ODD != 0);

  uart_state_t          state, state_next;
  logic                 rx_sync;
  logic [CW-1:0]        cnt;
  logic [3:0]           idx;
  logic [1:0]           smp;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 ferr_acc;
  logic                 wrap, decide, vote, frame_done, frame_bad;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    wrap       = baud_tick && (cnt == CNT_LAST);
    decide     = baud_tick && (cnt == SMP_LAST);
    vote       = maj3(smp[1], smp[0], rx_sync);
    frame_done = (state == ST_STOP) && decide && (idx == STOP_LAST);
    frame_bad  = ferr_acc | ~vote;
    state_next = state;
    case (state)
      ST_IDLE:   if (baud_tick && !rx_sync) state_next = ST_START;
      ST_START: begin
        if (decide && vote) state_next = ST_IDLE;
        else if (wrap)      state_next = ST_DATA;
      end
      ST_DATA:   if (wrap && idx == DATA_LAST) state_next = HAS_PAR ? ST_PARITY : ST_STOP;
      ST_PARITY: if (wrap) state_next = ST_STOP;
      ST_STOP:   if (frame_done) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Datapath advances only on baud_tick; rx_valid is the single exception.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      smp        <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      ferr_acc   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (baud_tick) begin
        if (state == ST_IDLE) begin
          cnt      <= '0;
          idx      <= '0;
          ferr_acc <= 1'b0;
          par_bit  <= 1'b0;
        end else begin
          cnt <= wrap ? '0 : cnt + CW'(1);
          if (cnt == SMP_FIRST || cnt == SMP_MID) smp <= {smp[0], rx_sync};
          if (state == ST_DATA && decide) shift <= {vote, shift[DATA_BITS-1:1]};
          if (state == ST_PARITY && decide) par_bit <= vote;
          if (state == ST_STOP && decide) ferr_acc <= frame_bad;
          if (wrap && (state == ST_DATA || state == ST_STOP))
            idx <= (state == ST_DATA && idx == DATA_LAST) ? '0 : idx + 4'd1;
        end
      end
      if (frame_done) begin
        rx_valid   <= 1'b1;
        rx_data    <= shift;
        parity_err <= HAS_PAR && ((^shift ^ par_bit) != ODD_PAR);
        frame_err  <= frame_bad;
        break_det  <= (shift == '0) && (!HAS_PAR || !par_bit) && frame_bad;
      end
    end
  end

endmodule
